// File: rtl/rx_frame_ctrl.sv
// rtl/rx_frame_ctrl.sv - serial receive frame controller: start detect, mid-bit strobes, stop check, host handshake.
// Optional even-parity frame bit and parity_error output when RX_PARITY_EN is defined.
module rx_frame_ctrl #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 10
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 serial_in,
`ifdef RX_PARITY_EN
  input  logic [DATA_BITS+1:0] packet_data,
`else
  input  logic [DATA_BITS:0]   packet_data,
`endif
  input  logic                 data_read,
  output logic                 shift_strobe,
  output logic                 sample_bit,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 overrun_error,
`ifdef RX_PARITY_EN
  output logic                 parity_error,
`endif
  output logic                 framing_error
);

`ifdef RX_PARITY_EN
  localparam int PKT_W = DATA_BITS + 2;
`else
  localparam int PKT_W = DATA_BITS + 1;
`endif
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int TW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(PKT_W + 1);

  typedef enum logic [2:0] {IDLE, START_CHK, RECV, CHECK, LOAD} state_t;

  state_t          state, next_state;
  logic            sync1, prev;
  logic [TW-1:0]   timer;
  logic [BW-1:0]   bit_cnt;
  logic            start_det, half_hit, bit_tick, last_bit, stop_ok, frame_ok;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1      <= 1'b1;
      sample_bit <= 1'b1;
      prev       <= 1'b1;
    end else begin
      sync1      <= serial_in;
      sample_bit <= sync1;
      prev       <= sample_bit;
    end
  end

  assign start_det = prev & ~sample_bit;
  assign half_hit  = (timer == TW'(HALF));
  assign bit_tick  = (timer == TW'(CLKS_PER_BIT - 1));
  assign last_bit  = (bit_cnt == BW'(PKT_W - 1));
  assign stop_ok   = packet_data[PKT_W-1];
`ifdef RX_PARITY_EN
  logic parity_ok;
  assign parity_ok = (packet_data[DATA_BITS] == ^packet_data[DATA_BITS-1:0]);
  assign frame_ok  = stop_ok & parity_ok;
`else
  assign frame_ok  = stop_ok;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state   = state;
    shift_strobe = 1'b0;
    case (state)
      IDLE:      if (start_det) next_state = START_CHK;
      START_CHK: if (half_hit) next_state = sample_bit ? IDLE : RECV;
      RECV: begin
        if (bit_tick) begin
          shift_strobe = 1'b1;
          if (last_bit) next_state = CHECK;
        end
      end
      CHECK:     next_state = frame_ok ? LOAD : IDLE;
      LOAD:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // timer counts cycles since the start-detect cycle, then restarts per bit once in RECV
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      timer   <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          timer   <= TW'(1);
          bit_cnt <= '0;
        end
        START_CHK: begin
          timer   <= half_hit ? '0 : timer + TW'(1);
          bit_cnt <= '0;
        end
        RECV: begin
          if (bit_tick) begin
            timer   <= '0;
            bit_cnt <= bit_cnt + BW'(1);
          end else begin
            timer   <= timer + TW'(1);
          end
        end
        default: begin
          timer   <= '0;
          bit_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_data       <= '1;
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
      framing_error <= 1'b0;
`ifdef RX_PARITY_EN
      parity_error  <= 1'b0;
`endif
    end else begin
      if (state == IDLE && start_det) begin
        framing_error <= 1'b0;
`ifdef RX_PARITY_EN
        parity_error  <= 1'b0;
`endif
      end
      if (state == CHECK && !stop_ok) framing_error <= 1'b1;
`ifdef RX_PARITY_EN
      if (state == CHECK && stop_ok && !parity_ok) parity_error <= 1'b1;
`endif
      // a load beats a same-cycle read: the new word stays pending
      if (state == LOAD) begin
        rx_data    <= packet_data[DATA_BITS-1:0];
        data_ready <= 1'b1;
        if (data_ready && !data_read)     overrun_error <= 1'b1;
        else if (data_ready && data_read) overrun_error <= 1'b0;
      end else if (data_read && data_ready) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb/tb_rx_frame_ctrl.sv - bench for rx_frame_ctrl with an ideal LSB-first shift register attached.
module tb_rx_frame_ctrl;
  localparam int DATA_BITS = 8;
  localparam int CLKS      = 10;
  localparam int HALF      = CLKS / 2;
  localparam int PKT_W     = DATA_BITS + 1;

  logic                 clk = 1'b0;
  logic                 n_rst = 1'b0;
  logic                 serial_in = 1'b1;
  logic                 data_read = 1'b0;
  logic [PKT_W-1:0]     packet_data;
  logic                 shift_strobe, sample_bit, data_ready, overrun_error, framing_error;
  logic [DATA_BITS-1:0] rx_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int frame_strobes = 0;
  int strobe_total = 0;
  int last_strobe_cyc = 0;
  int fall_cyc = 0;
  logic ready_prev = 1'b0;

  logic [7:0] m_rx = 8'hFF;
  logic       m_ready = 1'b0, m_ov = 1'b0, m_fe = 1'b0;

  typedef struct {
    logic [7:0] d;
    logic       stop;
    bit         rd_before;
    bit         rd_load;
    logic [7:0] e_rx;
    logic       e_ready;
    logic       e_ov;
    logic       e_fe;
  } vec_t;
  vec_t tbl[8];

  rx_frame_ctrl #(.DATA_BITS(DATA_BITS), .CLKS_PER_BIT(CLKS)) dut (
    .clk(clk), .n_rst(n_rst), .serial_in(serial_in), .packet_data(packet_data),
    .data_read(data_read), .shift_strobe(shift_strobe), .sample_bit(sample_bit),
    .rx_data(rx_data), .data_ready(data_ready), .overrun_error(overrun_error),
    .framing_error(framing_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge n_rst)
    if (!n_rst) packet_data <= '0;
    else if (shift_strobe) packet_data <= {sample_bit, packet_data[PKT_W-1:1]};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (n_rst) begin
      if (shift_strobe) begin
        if (frame_strobes == 0) chk("first_strobe_delay", cyc - fall_cyc, 2 + HALF + CLKS);
        else                    chk("strobe_spacing", cyc - last_strobe_cyc, CLKS);
        frame_strobes++;
        strobe_total++;
        last_strobe_cyc = cyc;
      end
      if (data_ready && !ready_prev) chk("ready_latency", cyc - last_strobe_cyc, 3);
    end
    ready_prev = data_ready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] rx, input logic rdy,
                               input logic ov, input logic fe);
    chk({tag, "_rx_data"}, int'(rx_data), int'(rx));
    chk({tag, "_data_ready"}, int'(data_ready), int'(rdy));
    chk({tag, "_overrun"}, int'(overrun_error), int'(ov));
    chk({tag, "_framing"}, int'(framing_error), int'(fe));
  endtask

  task automatic check_reset_values(input string tag);
    check_outputs(tag, 8'hFF, 1'b0, 1'b0, 1'b0);
    chk({tag, "_strobe"}, int'(shift_strobe), 0);
    chk({tag, "_sample_bit"}, int'(sample_bit), 1);
  endtask

  task automatic read_pulse();
    data_read = 1'b1;
    tick();
    data_read = 1'b0;
    tick();
    if (m_ready) begin
      m_ready = 1'b0;
      m_ov    = 1'b0;
    end
    chk("read_clears_ready", int'(data_ready), 0);
    chk("read_clears_overrun", int'(overrun_error), 0);
  endtask

  // Reference: one received frame under the host-visible rules.
  task automatic model_frame(input logic [7:0] d, input logic stop, input bit rd_load);
    m_fe = 1'b0;
    if (!stop) begin
      m_fe = 1'b1;
    end else begin
      if (m_ready && !rd_load) m_ov = 1'b1;
      else if (m_ready && rd_load) m_ov = 1'b0;
      m_ready = 1'b1;
      m_rx    = d;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input bit rd_load,
                            input int rst_at);
    logic [DATA_BITS+1:0] bits;
    bits = {stop, d, 1'b0};
    frame_strobes = 0;
    for (int c = 0; c <= 10 * CLKS + 5; c++) begin
      tick();
      if (c == 0) fall_cyc = cyc;
      serial_in = (c < 10 * CLKS) ? bits[c / CLKS] : 1'b1;
      data_read = rd_load && (frame_strobes == PKT_W) && (cyc == last_strobe_cyc + 2);
      if (rst_at > 0 && c == rst_at) begin
        #3;
        n_rst = 1'b0;
        #1;
        check_reset_values("midframe_reset");
        serial_in = 1'b1;
        data_read = 1'b0;
        m_rx = 8'hFF; m_ready = 1'b0; m_ov = 1'b0; m_fe = 1'b0;
        return;
      end
    end
    data_read = 1'b0;
    chk("strobes_per_frame", frame_strobes, PKT_W);
    model_frame(d, stop, rd_load);
  endtask

  initial begin
    logic [7:0] rd;
    logic       rs;
    bit         rb, rl;
    int         tot;

    tbl[0] = '{8'hA5, 1'b0, 0, 0, 8'hFF, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{8'hA5, 1'b1, 0, 0, 8'hA5, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'h3C, 1'b1, 1, 0, 8'h3C, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{8'hC3, 1'b1, 0, 0, 8'hC3, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{8'h00, 1'b0, 1, 0, 8'hC3, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{8'h7E, 1'b1, 0, 0, 8'h7E, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{8'h81, 1'b1, 0, 1, 8'h81, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{8'hFF, 1'b1, 0, 0, 8'hFF, 1'b1, 1'b1, 1'b0};

    repeat (3) tick();
    check_reset_values("reset");
    n_rst = 1'b1;
    repeat (4) tick();
    check_reset_values("post_reset_idle");

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].rd_before) read_pulse();
      send_frame(tbl[i].d, tbl[i].stop, tbl[i].rd_load, 0);
      check_outputs($sformatf("vec%0d", i), tbl[i].e_rx, tbl[i].e_ready, tbl[i].e_ov, tbl[i].e_fe);
      repeat (2) tick();
    end

    // Short low glitch: must be rejected as a false start.
    tot = strobe_total;
    serial_in = 1'b0;
    repeat (3) tick();
    serial_in = 1'b1;
    repeat (30) tick();
    chk("false_start_no_strobe", strobe_total, tot);
    check_outputs("false_start", 8'hFF, 1'b1, 1'b1, 1'b0);
    chk("false_start_sample_bit", int'(sample_bit), 1);

    for (int i = 0; i < 20; i++) begin
      rd = 8'($urandom);
      rs = ($urandom_range(0, 4) != 0);
      rb = bit'($urandom_range(0, 1));
      rl = rs && ($urandom_range(0, 1) == 1);
      if (rb) read_pulse();
      send_frame(rd, rs, rl, 0);
      check_outputs($sformatf("rand%0d", i), m_rx, m_ready, m_ov, m_fe);
      repeat ($urandom_range(1, 6)) tick();
    end

    send_frame(8'h5A, 1'b1, 0, 4 * CLKS + 5);
    repeat (3) tick();
    n_rst = 1'b1;
    repeat (4) tick();
    check_reset_values("after_reset_release");
    send_frame(8'h5A, 1'b1, 0, 0);
    check_outputs("recover", 8'h5A, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
